rr_mem_arbiter: RTL and testbench

Parametrised N-port arbiter that connects N cache pmem interfaces to one cacheline adaptor. It generalises the fixed two-port instruction/data arbiter in three ways: a configurable port count, a configurable line and address width, and a selectable round-robin or fixed-priority policy. It also supports write requests from any port. It sits between the L1 caches and cacheline_adaptor in the top level. Requests are granted, registered, and issued one at a time, and each completion is signalled with a registered single-cycle response.

---
 rtl/rr_mem_arbiter_pkg.sv | 36 +++
 rtl/rr_mem_arbiter_pick.sv | 26 ++
 rtl/rr_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_mem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mem_arbiter_pkg.sv
// Shared types and winner-selection helper for the pmem arbiters.
// Selection is pure combinational logic; it holds no state and exerts no backpressure.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int MAX_PORTS = 8;
  localparam int PICK_W    = 3;

  // Callers zero-fill pending above their port count. Scanning modulo 8 then
  // gives the same winner as scanning modulo the real port count.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [MAX_PORTS-1:0] pending,
    input logic [PICK_W-1:0]    ptr,
    input logic                 rr_mode
  );
    logic [PICK_W-1:0] idx;
    logic [PICK_W-1:0] win;
    logic              found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      idx = rr_mode ? ptr + PICK_W'(k) : PICK_W'(k);
      if (!found && pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_mem_arbiter_pick.sv
// Combinational winner selector: round-robin from ptr, or lowest index when rr_mode is 0.
// Latency 0 (combinational); no backpressure. winner is meaningful only when any_pending is high.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int PORT_IDX_W = 1
) (
  input  logic [NUM_PORTS-1:0]  pending,
  input  logic [PORT_IDX_W-1:0] ptr,
  input  logic                  rr_mode,
  output logic [PORT_IDX_W-1:0] winner,
  output logic                  any_pending
);

  logic [MAX_PORTS-1:0] pending_ext;
  logic [PICK_W-1:0]    ptr_ext;
  logic [PICK_W-1:0]    pick;

  assign pending_ext = MAX_PORTS'(pending);
  assign ptr_ext     = PICK_W'(ptr);
  assign pick        = rr_pick(pending_ext, ptr_ext, rr_mode);
  assign winner      = PORT_IDX_W'(pick);
  assign any_pending = |pending;

endmodule

// File: rtl/rr_mem_arbiter.sv
// N-port cacheline arbiter: grant, register and issue one request at a time to the adaptor.
// Latency: 1 cycle from request to strobe and 1 cycle from mem_resp to resp; losing ports wait with their request held.
module rr_mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int RR_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          req_read,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          resp,
  output logic [LINE_W-1:0]             rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_W-1:0]             mem_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id
);

  localparam int PORT_IDX_W = $clog2(NUM_PORTS);

  arb_state_e              state_q, state_d;
  logic [PORT_IDX_W-1:0]   ptr_q, ptr_d;
  logic [PORT_IDX_W-1:0]   grant_q, grant_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]    pending;
  logic [PORT_IDX_W-1:0]   winner;
  logic                    any_pending;
  logic [ADDR_W-1:0]       win_addr;
  logic [LINE_W-1:0]       win_wdata;

  assign pending   = req_read | req_write;
  assign win_addr  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata[int'(winner)*LINE_W +: LINE_W];

  rr_priority_pick #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_IDX_W (PORT_IDX_W)
  ) u_pick (
    .pending     (pending),
    .ptr         (ptr_q),
    .rr_mode     (RR_MODE != 0),
    .winner      (winner),
    .any_pending (any_pending)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          grant_d     = winner;
          mem_addr_d  = win_addr;
          mem_wdata_d = win_wdata;
          // A port asserting both is treated as a write.
          mem_write_d = req_write[winner];
          mem_read_d  = req_read[winner] & ~req_write[winner];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          rdata_d     = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // DONE always returns to IDLE so the requester gets one edge to drop its request.
        ptr_d   = (grant_q == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    resp = '0;
    if (state_q == DONE) resp[grant_q] = 1'b1;
  end

  assign rdata     = rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Bench for rr_mem_arbiter: 2-port round-robin, 2-port fixed-priority and 4-port round-robin instances.
module tb_rr_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // ---------------- instance A: 2 ports, round-robin ----------------
  logic         a_rst_n;
  logic [1:0]   a_req_read, a_req_write, a_resp;
  logic [63:0]  a_req_addr;
  logic [511:0] a_req_wdata;
  logic [255:0] a_rdata, a_mem_wdata, a_mem_rdata;
  logic         a_mem_read, a_mem_write, a_mem_resp;
  logic [31:0]  a_mem_addr;
  logic [0:0]   a_gid;

  rr_mem_arbiter #(.NUM_PORTS(2), .LINE_W(256), .ADDR_W(32), .RR_MODE(1)) dut_a (
    .clk(clk), .reset_n(a_rst_n), .req_read(a_req_read), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .resp(a_resp), .rdata(a_rdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_resp(a_mem_resp), .mem_rdata(a_mem_rdata), .grant_id(a_gid));

  // ---------------- instance F: 2 ports, fixed priority ----------------
  logic         rst_b;
  logic [1:0]   f_req_read, f_req_write, f_resp;
  logic [63:0]  f_req_addr;
  logic [511:0] f_req_wdata;
  logic [255:0] f_rdata, f_mem_wdata, f_mem_rdata;
  logic         f_mem_read, f_mem_write, f_mem_resp;
  logic [31:0]  f_mem_addr;
  logic [0:0]   f_gid;

  rr_mem_arbiter #(.NUM_PORTS(2), .LINE_W(256), .ADDR_W(32), .RR_MODE(0)) dut_f (
    .clk(clk), .reset_n(rst_b), .req_read(f_req_read), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .resp(f_resp), .rdata(f_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_resp(f_mem_resp), .mem_rdata(f_mem_rdata), .grant_id(f_gid));

  // ---------------- instance C: 4 ports, round-robin ----------------
  logic [3:0]    c_req_read, c_req_write, c_resp;
  logic [127:0]  c_req_addr;
  logic [1023:0] c_req_wdata;
  logic [255:0]  c_rdata, c_mem_wdata, c_mem_rdata, c_sent;
  logic          c_mem_read, c_mem_write, c_mem_resp;
  logic [31:0]   c_mem_addr;
  logic [1:0]    c_gid;

  rr_mem_arbiter #(.NUM_PORTS(4), .LINE_W(256), .ADDR_W(32), .RR_MODE(1)) dut_c (
    .clk(clk), .reset_n(rst_b), .req_read(c_req_read), .req_write(c_req_write),
    .req_addr(c_req_addr), .req_wdata(c_req_wdata), .resp(c_resp), .rdata(c_rdata),
    .mem_read(c_mem_read), .mem_write(c_mem_write), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_resp(c_mem_resp), .mem_rdata(c_mem_rdata), .grant_id(c_gid));

  // Adaptor stand-ins for F and C: answer each issued request after 0..3 extra cycles.
  initial begin
    f_mem_resp = 1'b0; f_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if ((f_mem_read | f_mem_write) && !f_mem_resp) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        f_mem_rdata = {8{$urandom()}};
        f_mem_resp  = 1'b1;
        @(posedge clk); #1;
        f_mem_resp  = 1'b0;
      end
    end
  end

  initial begin
    c_mem_resp = 1'b0; c_mem_rdata = '0; c_sent = '0;
    forever begin
      @(posedge clk); #1;
      if ((c_mem_read | c_mem_write) && !c_mem_resp) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        c_sent      = {8{$urandom()}};
        c_mem_rdata = c_sent;
        c_mem_resp  = 1'b1;
        @(posedge clk); #1;
        c_mem_resp  = 1'b0;
      end
    end
  end

  // ---------------- helpers for A ----------------
  task automatic a_respond(input int lat, input logic [7:0] rb);
    repeat (lat) begin @(posedge clk); #1; end
    a_mem_rdata = {32{rb}};
    a_mem_resp  = 1'b1;
    @(posedge clk); #1;
    a_mem_resp  = 1'b0;
  endtask

  task automatic a_wait_grant(input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (a_mem_read | a_mem_write) ok = 1;
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic f_wait_resp(input string name);
    bit ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      if (|f_resp) ok = 1;
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  // ---------------- reference model for C ----------------
  bit           m_pend[4], m_rd[4], m_wr[4];
  logic [31:0]  m_addr[4];
  logic [255:0] m_wd[4];
  int           m_ptr;

  task automatic c_drive();
    for (int p = 0; p < 4; p++) begin
      c_req_read[p]  = m_pend[p] & m_rd[p];
      c_req_write[p] = m_pend[p] & m_wr[p];
      c_req_addr[p*32 +: 32]    = m_addr[p];
      c_req_wdata[p*256 +: 256] = m_wd[p];
    end
  endtask

  task automatic c_raise(input int p);
    int kind = $urandom_range(0, 5);
    m_pend[p] = 1;
    m_rd[p]   = (kind <= 2) || (kind == 5);
    m_wr[p]   = (kind >= 3);
    m_addr[p] = {$urandom_range(0, 32'h3FF_FFFF), 6'b0};
    m_wd[p]   = {8{$urandom()}};
  endtask

  task automatic c_new_reqs();
    bit any = 0;
    for (int p = 0; p < 4; p++) begin
      if (!m_pend[p] && $urandom_range(0, 1) == 1) c_raise(p);
      any |= m_pend[p];
    end
    if (!any) c_raise($urandom_range(0, 3));
  endtask

  task automatic c_txn(input string name);
    int  win = -1;
    bit  ok  = 0;
    for (int k = 0; k < 4; k++)
      if (win < 0 && m_pend[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
    c_drive();
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (c_mem_read | c_mem_write) ok = 1;
    end
    if (!ok) begin chk({name, "_grant_timeout"}, 0, 1); return; end
    chk({name, "_gid"},   c_gid, win);
    chk({name, "_wr"},    c_mem_write, m_wr[win]);
    chk({name, "_rd"},    c_mem_read, m_rd[win] && !m_wr[win]);
    chk({name, "_addr"},  c_mem_addr, m_addr[win]);
    chk({name, "_wdata"}, c_mem_wdata, m_wd[win]);
    // Winner's inputs change mid-transaction; the issued request must not.
    c_req_addr[win*32 +: 32]    = $urandom();
    c_req_wdata[win*256 +: 256] = {8{$urandom()}};
    if ($urandom_range(0, 1) == 1) begin
      c_req_read[win] = 1'b0; c_req_write[win] = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      if (|c_resp) ok = 1;
    end
    if (!ok) begin chk({name, "_resp_timeout"}, 0, 1); return; end
    chk({name, "_resp"},  c_resp, 4'b0001 << win);
    chk({name, "_rdata"}, c_rdata, c_sent);
    chk({name, "_hold"},  c_mem_addr, m_addr[win]);
    m_ptr       = (win + 1) % 4;
    m_pend[win] = 0;
    c_drive();
  endtask

  // ---------------- directed table for A ----------------
  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] addr0, addr1;
    logic [15:0] wh0, wh1;
    logic [7:0]  rb;
    int          lat;
    int          exp_gid;
    logic        exp_rd, exp_wr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0]  e_addr;
    logic [255:0] e_wd;
    bit           seen;

    vecs[0] = '{2'b10, 2'b00, 32'h0,      32'h0000_1240, 16'h0,    16'h0,    8'hA5, 4, 1, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 2'b01, 32'h80,     32'h0,         16'h1234, 16'h0,    8'h3C, 2, 0, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 2'b00, 32'h100,    32'h200,       16'h0,    16'h0,    8'h11, 1, 1, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 2'b00, 32'h140,    32'h240,       16'h0,    16'h0,    8'h22, 1, 0, 1'b1, 1'b0};
    vecs[4] = '{2'b01, 2'b01, 32'h9C0,    32'h0,         16'hBEEF, 16'h0,    8'h33, 3, 0, 1'b0, 1'b1};
    vecs[5] = '{2'b01, 2'b10, 32'h500,    32'h600,       16'h5555, 16'hCAFE, 8'h44, 1, 1, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 2'b00, 32'h0,      32'h7C0,       16'h0,    16'h0,    8'h55, 2, 1, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 2'b10, 32'hFFC0,   32'h840,       16'h0,    16'h7777, 8'h66, 0, 0, 1'b1, 1'b0};

    a_rst_n = 1'b0; rst_b = 1'b0;
    a_req_read = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
    a_mem_resp = 1'b0; a_mem_rdata = '0;
    f_req_read = '0; f_req_write = '0; f_req_addr = '0; f_req_wdata = '0;
    c_req_read = '0; c_req_write = '0; c_req_addr = '0; c_req_wdata = '0;
    for (int p = 0; p < 4; p++) begin m_pend[p] = 0; m_rd[p] = 0; m_wr[p] = 0; m_addr[p] = 0; m_wd[p] = 0; end
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_strobes", {a_resp, a_mem_read, a_mem_write}, 0);
    chk("rst_a_addr", a_mem_addr, 0);
    chk("rst_a_data", a_mem_wdata | a_rdata, 0);
    chk("rst_a_gid", a_gid, 0);
    chk("rst_c_outs", {c_resp, c_mem_read, c_mem_write, c_gid}, 0);
    a_rst_n = 1'b1; rst_b = 1'b1;

    // Table: each vector starts in IDLE; strobes must appear exactly one edge later.
    for (int i = 0; i < 8; i++) begin
      a_req_read  = vecs[i].rd;
      a_req_write = vecs[i].wr;
      a_req_addr  = {vecs[i].addr1, vecs[i].addr0};
      a_req_wdata = {{16{vecs[i].wh1}}, {16{vecs[i].wh0}}};
      e_addr = (vecs[i].exp_gid == 1) ? vecs[i].addr1 : vecs[i].addr0;
      e_wd   = (vecs[i].exp_gid == 1) ? {16{vecs[i].wh1}} : {16{vecs[i].wh0}};
      @(posedge clk); #1;
      chk($sformatf("v%0d_gid", i),   a_gid, vecs[i].exp_gid);
      chk($sformatf("v%0d_rd", i),    a_mem_read, vecs[i].exp_rd);
      chk($sformatf("v%0d_wr", i),    a_mem_write, vecs[i].exp_wr);
      chk($sformatf("v%0d_addr", i),  a_mem_addr, e_addr);
      chk($sformatf("v%0d_wdata", i), a_mem_wdata, e_wd);
      a_req_addr  = {$urandom(), $urandom()};
      a_req_wdata = {16{$urandom()}};
      a_respond(vecs[i].lat, vecs[i].rb);
      chk($sformatf("v%0d_resp", i),  a_resp, 2'b01 << vecs[i].exp_gid);
      chk($sformatf("v%0d_rdata", i), a_rdata, {32{vecs[i].rb}});
      chk($sformatf("v%0d_clr", i),   {a_mem_read, a_mem_write}, 2'b00);
      chk($sformatf("v%0d_hold", i),  a_mem_addr, e_addr);
      a_req_read = '0; a_req_write = '0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse1", i), a_resp, 2'b00);
    end

    // Both ports held from reset: grants alternate 0,1,0,1.
    a_rst_n = 1'b0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    a_req_read = 2'b11;
    a_req_addr = {32'h1000, 32'h2000};
    for (int k = 0; k < 4; k++) begin
      a_wait_grant($sformatf("alt%0d", k));
      chk($sformatf("alt%0d_gid", k), a_gid, k % 2);
      a_respond(1, 8'(k));
      chk($sformatf("alt%0d_resp", k), a_resp, 2'b01 << (k % 2));
    end
    a_req_read = '0;
    @(posedge clk); #1;

    // Port 0 drops its request while BUSY: completes once, never re-granted.
    a_req_read = 2'b01;
    a_req_addr = {32'h0, 32'h3300};
    @(posedge clk); #1;
    chk("drop_rd", a_mem_read, 1);
    a_req_read = '0;
    a_respond(2, 8'h77);
    chk("drop_resp", a_resp, 2'b01);
    chk("drop_rdata", a_rdata, {32{8'h77}});
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen |= (a_mem_read | a_mem_write | (|a_resp)); end
    chk("drop_no_regrant", seen, 0);

    // Reset for one cycle during BUSY; a late mem_resp must be ignored.
    a_req_read = 2'b01;
    a_req_addr = {32'h0, 32'h440};
    @(posedge clk); #1;
    chk("rb_busy", a_mem_read, 1);
    a_rst_n = 1'b0;
    a_req_read = '0;
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    chk("rb_strobes", {a_resp, a_mem_read, a_mem_write}, 0);
    chk("rb_addr_gid", {a_mem_addr, a_gid}, 0);
    chk("rb_data", a_mem_wdata | a_rdata, 0);
    a_mem_rdata = {32{8'hEE}};
    a_mem_resp  = 1'b1;
    @(posedge clk); #1;
    a_mem_resp  = 1'b0;
    seen = 0;
    repeat (3) begin @(posedge clk); #1; seen |= ((|a_resp) | a_mem_read | a_mem_write); end
    chk("rb_late_ignored", seen, 0);
    chk("rb_rdata_kept", a_rdata, 0);
    a_req_read = 2'b10;
    a_req_addr = {32'h0000_0300, 32'h0};
    @(posedge clk); #1;
    chk("rb_fresh_gid", a_gid, 1);
    chk("rb_fresh_addr", a_mem_addr, 32'h300);
    a_respond(1, 8'h5A);
    chk("rb_fresh_resp", a_resp, 2'b10);
    a_req_read = '0;

    // Fixed priority: port 0 wins while held; port 1 only after it drops.
    f_req_read = 2'b11;
    f_req_addr = {32'h1100, 32'h2200};
    for (int k = 0; k < 3; k++) begin
      f_wait_resp($sformatf("fix%0d", k));
      chk($sformatf("fix%0d_resp", k), f_resp, 2'b01);
      chk($sformatf("fix%0d_gid", k), f_gid, 0);
      chk($sformatf("fix%0d_addr", k), f_mem_addr, 32'h2200);
    end
    f_req_read = 2'b10;
    f_wait_resp("fix_p1");
    chk("fix_p1_resp", f_resp, 2'b10);
    chk("fix_p1_addr", f_mem_addr, 32'h1100);
    f_req_read = '0;

    // 4 ports: grant to port 3, then ports 0 and 3 pending -> wrap to port 0.
    c_raise(3);
    c_txn("wrapA");
    c_raise(0);
    c_raise(3);
    c_txn("wrapB");
    chk("wrap_gid", c_gid, 0);

    for (int t = 0; t < 40; t++) begin
      c_new_reqs();
      c_txn($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
